// File: rtl/fx_mult_arb_pkg.sv
// Shared types and default sizing for the fixed-point multiplier arbiter.
package fx_mult_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_N    = 32;
  localparam int DEF_Q    = 15;
  localparam int DEF_NREQ = 4;

endpackage

// File: rtl/fx_mult.sv
// Combinational sign-magnitude Q-format multiplier, truncating.
// Optional FX_MULT_ARB_SATURATE_EN clamps the magnitude to all-ones on overflow.
module fx_mult #(
  parameter int N = 32,
  parameter int Q = 15
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] p,
  output logic         ovf
);

  logic [2*N-3:0] prod;
  logic           sign;
  logic [N-2:0]   mag;

  assign prod = {{(N-1){1'b0}}, a[N-2:0]} * {{(N-1){1'b0}}, b[N-2:0]};
  assign sign = a[N-1] ^ b[N-1];
  assign mag  = prod[N-2+Q:Q];
  assign ovf  = |prod[2*N-3:N-1+Q];

`ifdef FX_MULT_ARB_SATURATE_EN
  assign p = ovf ? {sign, {(N-1){1'b1}}} : {sign, mag};
`else
  // Overflow leaves the wrapped (truncated) magnitude in place.
  assign p = {sign, mag};
`endif

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  index,
  output logic            any
);

  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[(int'(ptr) + i) % NREQ]) begin
        any                            = 1'b1;
        grant[(int'(ptr) + i) % NREQ]  = 1'b1;
        index                          = IDW'((int'(ptr) + i) % NREQ);
      end
    end
  end

endmodule

// File: rtl/fx_mult_arbiter.sv
// Round-robin sharing of one fx_mult among NREQ requesters; 3 cycles per product.
// Saturating overflow behaviour selected by FX_MULT_ARB_SATURATE_EN.
module fx_mult_arbiter
  import fx_mult_arb_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int Q    = DEF_Q,
  parameter int NREQ = DEF_NREQ,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [NREQ-1:0]   req_valid_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic [NREQ*N-1:0] multiplicand_i,
  input  logic [NREQ*N-1:0] multiplier_i,
  output logic [NREQ-1:0]   resp_valid_o,
  output logic [N-1:0]      result_o,
  output logic              overflow_o,
  output logic [IDW-1:0]    grant_id_o,
  output logic              busy_o
);

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr;
  logic [N-1:0]    op_a, op_b;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic            accept;
  logic [N-1:0]    mul_p;
  logic            mul_ovf;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_valid_i),
    .ptr   (ptr),
    .grant (gnt),
    .index (gnt_idx),
    .any   (gnt_any)
  );

  fx_mult #(.N(N), .Q(Q)) u_mult (
    .a   (op_a),
    .b   (op_b),
    .p   (mul_p),
    .ovf (mul_ovf)
  );

  assign accept       = (state == IDLE) && gnt_any;
  assign req_ready_o  = (state == IDLE) ? gnt : '0;
  assign resp_valid_o = (state == RESP) ? (NREQ'(1) << grant_id_o) : '0;
  assign busy_o       = (state != IDLE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MUL;
      MUL:     state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      grant_id_o <= '0;
      result_o   <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (accept) begin
        op_a       <= multiplicand_i[gnt_idx*N +: N];
        op_b       <= multiplier_i[gnt_idx*N +: N];
        grant_id_o <= gnt_idx;
        ptr        <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      end
      // Result registers hold between transactions.
      if (state == MUL) begin
        result_o   <= mul_p;
        overflow_o <= mul_ovf;
      end
    end
  end

endmodule

// File: tb/tb_fx_mult_arbiter.sv
// Directed self-checking bench for fx_mult_arbiter (N=32, Q=15, NREQ=4).
module tb_fx_mult_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] mcand;
  logic [127:0] mplier;
  logic [3:0]   resp_valid;
  logic [31:0]  result;
  logic         overflow;
  logic [1:0]   grant_id;
  logic         busy;

  int total = 0;
  int bad   = 0;

  fx_mult_arbiter #(.N(32), .Q(15), .NREQ(4)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .multiplicand_i (mcand),
    .multiplier_i   (mplier),
    .resp_valid_o   (resp_valid),
    .result_o       (result),
    .overflow_o     (overflow),
    .grant_id_o     (grant_id),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int k, input logic [31:0] a, input logic [31:0] b);
    mcand[k*32 +: 32]  = a;
    mplier[k*32 +: 32] = b;
  endtask

  task automatic wait_ready(input int k);
    int n = 0;
    while (!req_ready[k] && n < 20) begin
      step();
      n++;
    end
    check_eq("ready_wait", req_ready[k], 1'b1);
  endtask

  task automatic do_txn(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic eo);
    set_op(k, a, b);
    req_valid[k] = 1'b1;
    #1;
    wait_ready(k);
    check_eq("ready_onehot", req_ready, 4'b1 << k);
    step();
    req_valid[k] = 1'b0;
    check_eq("mul_busy", busy, 1'b1);
    check_eq("mul_ready", req_ready, 4'b0);
    check_eq("mul_resp", resp_valid, 4'b0);
    check_eq("mul_gid", grant_id, k[1:0]);
    step();
    check_eq("resp_valid", resp_valid, 4'b1 << k);
    check_eq("resp_result", result, er);
    check_eq("resp_ovf", overflow, eo);
    check_eq("resp_busy", busy, 1'b1);
    step();
    check_eq("post_resp", resp_valid, 4'b0);
    check_eq("post_busy", busy, 1'b0);
    check_eq("post_hold", result, er);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, req_ready, 4'b0);
    check_eq({tag, "_resp"}, resp_valid, 4'b0);
    check_eq({tag, "_result"}, result, 32'h0);
    check_eq({tag, "_ovf"}, overflow, 1'b0);
    check_eq({tag, "_gid"}, grant_id, 2'd0);
    check_eq({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    logic [31:0] ovf_exp;
    int ord [5];
    int n;
    int last;
    int cur;

    rst_n     = 1'b0;
    req_valid = '0;
    mcand     = '0;
    mplier    = '0;
    #12;
    check_reset_outputs("rst");
    step();
    rst_n = 1'b1;
    step();
    check_reset_outputs("idle");

    // 1.5 x 2.0 = 3.0
    do_txn(0, 32'h0000C000, 32'h00010000, 32'h00018000, 1'b0);
    // -1.0 x 2.0 = -2.0, leaves ptr at 3
    do_txn(2, 32'h80008000, 32'h00010000, 32'h80010000, 1'b0);

    // Requests on 1 and 3 with ptr=3: 3 wins, then wrap to 1.
    set_op(1, 32'h00018000, 32'h00010000);
    set_op(3, 32'h00004000, 32'h00004000);
    req_valid = 4'b1010;
    #1;
    check_eq("wrap_first_rdy", req_ready, 4'b1000);
    step();
    req_valid[3] = 1'b0;
    check_eq("wrap_first_gid", grant_id, 2'd3);
    check_eq("wrap_pend_rdy", req_ready, 4'b0);
    step();
    check_eq("wrap_first_resp", resp_valid, 4'b1000);
    check_eq("wrap_first_res", result, 32'h00002000);
    step();
    check_eq("wrap_second_rdy", req_ready, 4'b0010);
    step();
    req_valid[1] = 1'b0;
    check_eq("wrap_second_gid", grant_id, 2'd1);
    step();
    check_eq("wrap_second_resp", resp_valid, 4'b0010);
    check_eq("wrap_second_res", result, 32'h00030000);
    step();

`ifdef FX_MULT_ARB_SATURATE_EN
    ovf_exp = 32'h7FFFFFFF;
`else
    ovf_exp = 32'h7FFE0000;
`endif
    do_txn(1, 32'h7FFFFFFF, 32'h7FFFFFFF, ovf_exp, 1'b1);

    // Reset while in MUL: transaction dropped, everything back to reset values.
    set_op(2, 32'h00010000, 32'h00010000);
    req_valid[2] = 1'b1;
    #1;
    check_eq("rmul_rdy", req_ready, 4'b0100);
    step();
    req_valid[2] = 1'b0;
    check_eq("rmul_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rmul");
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("rmul_nostrobe", resp_valid, 4'b0);
      step();
    end

    // Fairness: all four held valid, expect 0,1,2,3,0 every 3 cycles.
    for (int k = 0; k < 4; k++) set_op(k, 32'((k + 1) << 15), 32'h00010000);
    ord = '{0, 1, 2, 3, 0};
    n = 0;
    last = 0;
    cur = 0;
    req_valid = 4'b1111;
    #1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (busy) begin
        check_eq("fair_rdy_busy", req_ready, 4'b0);
      end else if (req_ready != 4'b0 && n < 5) begin
        check_eq("fair_grant", req_ready, 4'b1 << ord[n]);
        if (n > 0) check_eq("fair_spacing", cyc - last, 3);
        last = cyc;
        cur  = ord[n];
        n++;
      end
      if (resp_valid != 4'b0) begin
        check_eq("fair_resp", resp_valid, 4'b1 << cur);
        check_eq("fair_res", result, 32'((cur + 1) << 16));
        check_eq("fair_gid", grant_id, cur[1:0]);
      end
      step();
    end
    req_valid = '0;
    check_eq("fair_count", n, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fx_mult_arbiter.md
# fx_mult_arbiter

Round-robin controller that shares one combinational Q-format fixed-point multiplier (`fx_mult`) between NREQ requesters, such as per-axis stepper velocity/acceleration scalers.
- Accepts one operand pair at a time over a valid/ready handshake.
- Registers the operands into the multiplier and samples its output.
- Returns result and overflow flag to the granting requester with a one-cycle response strobe.
- Sits between the motion-profile logic and the shared multiplier.

## Interface
- N, 32, word width (sign-magnitude fixed point, sign in MSB)
- Q, 15, fractional bits
- NREQ, 4, number of requesters (2..16)
- IDW, $clog2(NREQ), grant index width (derived, localparam)

- clk_i  in  1  single clock, rising edge
- rst_n_i  in  1  asynchronous active-low reset
- req_valid_i  in  NREQ  per-requester request
- req_ready_o  out  NREQ  one-hot acceptance, combinational in IDLE
- multiplicand_i  in  NREQ*N  flattened operands, requester k at [k*N +: N]
- multiplier_i  in  NREQ*N  flattened operands
- resp_valid_o  out  NREQ  one-hot, one-cycle response strobe
- result_o  out  N  product, valid while resp_valid_o != 0
- overflow_o  out  1  overflow flag, valid with result_o
- grant_id_o  out  IDW  index of current/last granted requester
- busy_o  out  1  high in MUL and RESP

## Operation
- Arithmetic (as fx_mult):
  - sign = a[N-1]^b[N-1]
  - P = a[N-2:0]*b[N-2:0] (2N-2 bits)
  - magnitude = P[N-2+Q:Q]
  - overflow = |P[2N-3:N-1+Q]
  - Truncation only, no rounding; -0 is legal output.
- FSM states: IDLE, MUL, RESP.
- IDLE:
  - Grant = first k with req_valid_i[k], searching from ptr, ptr+1, … mod NREQ.
  - req_ready_o[grant]=1; all other ready bits 0.
  - On handshake: latch operands into op_a/op_b, grant_id_o<=k, ptr<=k+1 mod NREQ, go to MUL.
  - With no valid request, stay in IDLE.
- MUL: the multiplier settles on op_a/op_b. At the clock edge, register result/overflow and go to RESP.
- RESP: resp_valid_o[grant_id_o]=1 for exactly one cycle, then IDLE.
- No response backpressure; the requester must consume the strobe.
- Requesters hold operands stable while valid and may drop valid before being granted.
- Ungranted requesters wait; starvation bound is NREQ-1 transactions.

## Timing
- Reset values:
  - state=IDLE, ptr=0, op_a/op_b=0
  - result_o=0, overflow_o=0, resp_valid_o=0, grant_id_o=0, busy_o=0
  - req_ready_o=0 until the first valid request
- Latency: handshake at edge t → resp_valid_o high in cycle t+2 → next acceptance possible at edge t+3.
- Throughput: one product per 3 cycles.
- req_ready_o is 0 in MUL/RESP, even with valid requests pending.
- Simultaneous requests: resolved purely by ptr. After reset, ptr=0 gives order 0,1,…,NREQ-1.
- ptr wraps from NREQ-1 to 0.
- Reset asserted mid-MUL/RESP: the transaction is dropped and no strobe is issued. All outputs and ptr return to reset values asynchronously.
- result_o/overflow_o hold their last value outside RESP.

## Configuration
- FX_MULT_ARB_SATURATE_EN defined: on overflow, result_o = {sign, {N-1{1'b1}}} and overflow_o=1.
- Not defined: result_o = {sign, truncated magnitude} and overflow_o=1 (wrapped value).

## Structure
- Package fx_mult_arb_pkg contains:
  - FSM state typedef (IDLE/MUL/RESP)
  - default N/Q/NREQ constants
- Sub-module rr_arbiter (NREQ): inputs req, ptr; outputs one-hot grant, index, any.
- `fx_mult` is instantiated once on op_a/op_b.

## Test plan
- Single request, N=32/Q=15: requester 0 sends 0x0000C000 × 0x00010000 (1.5×2.0) → resp_valid_o=0001 at t+2, result 0x00018000, overflow 0.
- Sign: requester 2 sends 0x80008000 × 0x00010000 (-1.0×2.0) → result 0x80010000, resp_valid_o=0100, grant_id_o=2.
- Overflow: 0x7FFFFFFF × 0x7FFFFFFF → overflow_o=1. Result 0x7FFE0000 without the macro; 0x7FFFFFFF with FX_MULT_ARB_SATURATE_EN.
- Fairness: all four valid, held continuously after reset → grants 0,1,2,3,0 at acceptances spaced 3 cycles apart. ready is never high in MUL/RESP.
- Wrap/skip: ptr=3 with requests on 1 and 3 only → 3 first, then 1.
- Reset during MUL → no resp_valid_o. After release, the first grant goes to requester 0 and all outputs read 0.
